reg_bank_arbiter: RTL and testbench

Shares write access to a bank of DEPTH flip-flop registers among NREQ requesters. Arbitration is round-robin, with one write per cycle.
A clear sequencer zeroes the whole bank, one register per cycle, on command. It gives the bank a synchronous whole-bank clear alongside the per-register asynchronous reset.
The block sits between requester logic and the storage flops. It owns every write into the bank and provides one combinational read port.

---
 rtl/reg_bank_arbiter.sv | 126 ++++++++++++
 tb/tb_reg_bank_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter in front of a DEPTH-entry register bank, with a
// one-register-per-cycle clear sweep and a combinational read port.
module reg_bank_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  input  logic              clear_start,
  output logic              busy,
  input  logic [AW-1:0]     rd_addr,
  output logic [W-1:0]      rd_data
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]      state, next_state;
  logic [PW-1:0]   ptr, ptr_d;
  logic [AW-1:0]   idx, idx_d;
  logic [NREQ-1:0] gnt_d;
  logic [NREQ-1:0] elig;
  logic            busy_d;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [W-1:0]    wr_data;
  logic            win_valid;
  logic [PW-1:0]   win_idx;
  logic [W-1:0]    bank [DEPTH];

  // Last cycle's winner sits out one cycle so a held request is not written twice
  assign elig = req & ~gnt;

  // First eligible requester starting at ptr, wrapping at NREQ
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned   cand;
      logic [PW-1:0] cand_idx;
      cand = 32'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = PW'(cand);
      if (!win_valid && elig[cand_idx]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state, grant, pointer and bank write selection
  always_comb begin
    next_state = state;
    ptr_d      = ptr;
    idx_d      = idx;
    gnt_d      = '0;
    busy_d     = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    case (state)
      IDLE: begin
        if (clear_start) begin
          next_state = CLEAR;
          busy_d     = 1'b1;
        end else if (win_valid) begin
          gnt_d   = NREQ'(1) << win_idx;
          ptr_d   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
          wr_en   = 1'b1;
          wr_addr = req_addr[32'(win_idx) * AW +: AW];
          wr_data = req_data[32'(win_idx) * W +: W];
        end
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = idx;
        busy_d  = 1'b1;
        if (idx == AW'(DEPTH - 1)) begin
          next_state = IDLE;
          idx_d      = '0;
          busy_d     = 1'b0;
        end else begin
          idx_d = idx + AW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr  <= '0;
      idx  <= '0;
      gnt  <= '0;
      busy <= 1'b0;
    end else begin
      ptr  <= ptr_d;
      idx  <= idx_d;
      gnt  <= gnt_d;
      busy <= busy_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else if (wr_en) begin
      bank[wr_addr] <= wr_data;
    end
  end

  assign rd_data = bank[rd_addr];

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: reset, single write, round-robin,
// wrap/skip, clear sweep and reset abort, all with hand-derived expectations.
`timescale 1ns/1ps
module tb_reg_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [11:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        clear_start;
  logic        busy;
  logic [2:0]  rd_addr;
  logic [7:0]  rd_data;

  int checks = 0;
  int errors = 0;
  int cnt [4];
  int rnd [4];

  reg_bank_arbiter #(.NREQ(4), .W(8), .DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
    .req_data(req_data), .gnt(gnt), .clear_start(clear_start),
    .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input string tag, input logic [2:0] a, input logic [7:0] e);
    rd_addr = a;
    #1;
    check(tag, 32'(rd_data), 32'(e));
  endtask

  task automatic set_req(input int k, input logic [2:0] a, input logic [7:0] d);
    req_addr[k*3 +: 3] = a;
    req_data[k*8 +: 8] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = '0; req_addr = '0; req_data = '0;
    clear_start = 1'b0; rd_addr = '0;

    // Reset state without any clock edge
    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    for (int a = 0; a < 8; a++) chk_rd("rst_rd", 3'(a), 8'h00);
    tick();
    reset = 1'b0;
    tick();

    // Round-robin: all four requesting for 12 cycles
    for (int k = 0; k < 4; k++) begin
      cnt[k] = 0; rnd[k] = 0;
      set_req(k, 3'(k), 8'(8'h10 + k));
    end
    req = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("rr_gnt", 32'(gnt), 32'(1 << (i % 4)));
      for (int k = 0; k < 4; k++) begin
        if (gnt[k]) begin
          cnt[k]++;
          rnd[k]++;
          set_req(k, 3'((k + 4 * rnd[k]) % 8), 8'(16 * (rnd[k] + 1) + k));
        end
      end
    end
    req = '0;
    for (int k = 0; k < 4; k++) check("rr_count", 32'(cnt[k]), 32'd3);
    for (int a = 0; a < 4; a++) chk_rd("rr_bank_lo", 3'(a), 8'(8'h30 + a));
    for (int a = 4; a < 8; a++) chk_rd("rr_bank_hi", 3'(a), 8'(8'h20 + a - 4));

    // Single write from requester 2; held request masked in gnt cycle
    set_req(2, 3'd5, 8'hA5);
    req = 4'b0100;
    tick();
    check("single_gnt", 32'(gnt), 32'h4);
    chk_rd("single_rd", 3'd5, 8'hA5);
    tick();
    check("single_mask", 32'(gnt), 32'h0);
    req = '0;

    // Wrap and skip from ptr=3
    set_req(0, 3'd1, 8'h11);
    set_req(2, 3'd2, 8'h22);
    req = 4'b0101;
    tick();
    check("wrap_gnt0", 32'(gnt), 32'h1);
    tick();
    check("wrap_gnt2", 32'(gnt), 32'h4);
    tick();
    check("wrap_gnt0b", 32'(gnt), 32'h1);
    req = '0;
    chk_rd("wrap_rd1", 3'd1, 8'h11);
    chk_rd("wrap_rd2", 3'd2, 8'h22);
    tick();
    check("wrap_idle", 32'(gnt), 32'h0);

    // Fill bank with FF
    for (int a = 0; a < 8; a++) begin
      set_req(a % 4, 3'(a), 8'hFF);
      req = 4'(1 << (a % 4));
      tick();
      check("fill_gnt", 32'(gnt), 32'(1 << (a % 4)));
      req = '0;
      tick();
    end
    for (int a = 0; a < 8; a++) chk_rd("fill_rd", 3'(a), 8'hFF);

    // Clear sweep with req[1] pending and a stray clear_start mid-sweep
    set_req(1, 3'd6, 8'h5A);
    req = 4'b0010;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("clr_busy", 32'(busy), 32'h1);
      check("clr_gnt", 32'(gnt), 32'h0);
      if (i == 3) clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
    end
    check("clr_done_busy", 32'(busy), 32'h0);
    check("clr_done_gnt", 32'(gnt), 32'h0);
    for (int a = 0; a < 8; a++) chk_rd("clr_rd", 3'(a), 8'h00);
    tick();
    check("clr_resume_gnt", 32'(gnt), 32'h2);
    chk_rd("clr_resume_rd", 3'd6, 8'h5A);
    req = '0;
    tick();
    check("clr_no_restart", 32'(busy), 32'h0);

    // Abort a sweep with reset at sweep cycle 3
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    check("abort_busy_on", 32'(busy), 32'h1);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_gnt", 32'(gnt), 32'h0);
    for (int a = 0; a < 8; a++) chk_rd("abort_rd", 3'(a), 8'h00);
    reset = 1'b0;
    tick();
    check("abort_idle1", 32'(busy), 32'h0);
    tick();
    check("abort_idle2", 32'(busy), 32'h0);

    // Pointer restarted at 0: requester 1 beats requester 3
    set_req(1, 3'd3, 8'h77);
    set_req(3, 3'd4, 8'h88);
    req = 4'b1010;
    tick();
    check("ptr_rst_gnt1", 32'(gnt), 32'h2);
    req = 4'b1000;
    tick();
    check("ptr_rst_gnt3", 32'(gnt), 32'h8);
    req = '0;
    chk_rd("ptr_rst_rd3", 3'd3, 8'h77);
    chk_rd("ptr_rst_rd4", 3'd4, 8'h88);

    // Fresh sweep after abort needs its own clear_start
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("resweep_busy", 32'(busy), 32'h1);
      tick();
    end
    check("resweep_done", 32'(busy), 32'h0);
    chk_rd("resweep_rd3", 3'd3, 8'h00);
    chk_rd("resweep_rd4", 3'd4, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
